int_ex: RTL and testbench
=========================

// Module: int_ex
// PURPOSE
//  Integer execution unit directly downstream of the reservation station (rs). Accepts one ready
//  instruction per cycle (operand values, tag, dest phys reg), computes RV64I ALU ops in one cycle and
//  MUL iteratively. Drives the result back to rs on the int forwarding path and to the ROB by tag.
//  Throttles rs via stop_ex2rs while a MUL is in flight or the result register is blocked.
// PARAMETERS
//  XLEN      64  operand/result width
//  TAG_W     6   ROB tag and physical register index width
//  MUL_STEP  4   multiplier bits retired per cycle; must divide XLEN (MUL takes XLEN/MUL_STEP cycles)
// PORTS
//  clk            in   1      clock, all state on rising edge
//  res_n          in   1      reset, asynchronous, active-low
//  opcode_rs2ex   in   7      RV opcode
//  funct3_rs2ex   in   3      funct3
//  imm_rs2ex      in   12     I-type immediate; R-type: imm[11:5] carries funct7
//  tag_rs2ex      in   TAG_W  ROB tag
//  rs1_rs2ex      in   XLEN   operand 1 value
//  rs2_rs2ex      in   XLEN   operand 2 value (ignored for I-type)
//  rd_rs2ex       in   TAG_W  destination physical register
//  valid_rs2ex    in   1      instruction present
//  stop_ex2rs     out  1      1 = do not issue; combinational
//  result_int2rs  out  XLEN   forwarded result
//  rd_int2rs      out  TAG_W  forwarded dest phys reg
//  valid_int2rs   out  1      forward strobe, one cycle per instruction
//  result_ex2rob  out  XLEN   result to ROB
//  tag_ex2rob     out  TAG_W  ROB tag of result
//  valid_ex2rob   out  1      result register occupied
//  ready_rob2ex   in   1      ROB accepts result this cycle
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, result register empty; reset mid-MUL discards the MUL, no output.
//  Accept = valid_rs2ex & ~stop_ex2rs at a rising edge. stop_ex2rs = (state!=IDLE) | (valid_ex2rob & ~ready_rob2ex).
//  ROB handshake: transfer when valid_ex2rob & ready_rob2ex; outputs held stable while ready low.
//  Decode, opcode 0110011 (R): funct7 0000000 ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND by funct3;
//   funct7 0100000 with funct3 000 SUB, 101 SRA; funct7 0000001 funct3 000 MUL (low XLEN bits).
//  Opcode 0010011 (I): ADDI/SLTI/SLTIU/XORI/ORI/ANDI; imm sign-extended 12->XLEN;
//   SLLI/SRLI/SRAI shamt=imm[5:0], imm[10]=1 selects SRAI. Shift amounts R-type use rs2[5:0].
//  Any other opcode/funct combination: result 0, still delivered to ROB and forward path.
//  Arithmetic modulo 2^XLEN; SLT signed, SLTU unsigned, result 0/1 zero-extended.
//  ALU latency: accepted at edge N -> result register loaded at edge N, visible after N.
//  FSM IDLE/MUL/MWAIT. IDLE + accepted MUL -> MUL, latch tag, rd, operands, clear accumulator.
//  MUL: each cycle add (multiplicand * low MUL_STEP bits of multiplier) to acc, shift operands;
//   on final step (XLEN/MUL_STEP cycles after accept) load result register if empty or draining
//   this edge -> IDLE; otherwise -> MWAIT holding final product. MWAIT -> IDLE when register frees.
//  Result register load and ROB drain in the same edge: new result replaces old, no bubble.
//  valid_int2rs pulses exactly in the cycle after the result register is loaded, not repeated while
//   ROB stalls; result_int2rs/rd_int2rs match the loaded value during that cycle.
//  Back-to-back ALU ops with ready_rob2ex=1: one result per cycle, stop_ex2rs stays 0.
// TESTING
//  ADD rs1=530 rs2=714 tag=13 rd=1, ready=1 -> next cycle valid_int2rs=1, result 1244, rd 1, tag 13.
//  SUB 5-7; SRAI rs1=-16 imm[10]=1 shamt 2 -> 0xFFFF_FFFF_FFFF_FFFE then 0xFFFF_FFFF_FFFF_FFFC (-4).
//  MUL 323*545 MUL_STEP=4 -> stop_ex2rs high 16 cycles, result 176035, single valid_int2rs pulse.
//  ready_rob2ex=0 after ADDI 10+(-3): valid_ex2rob held, result 7 stable, stop high, issue ignored.
//  MUL completes while register blocked -> MWAIT; raise ready -> old drains, product loads next edge.
//  res_n low 5 cycles into MUL -> all outputs 0 immediately; after release no stale result emitted.

Source files
------------

// File: rtl/int_ex.sv
// Integer execution unit fed by the reservation station.
// Single-cycle RV64I ALU operations plus an iterative MUL that retires
// MUL_STEP multiplier bits per cycle. Results go to the ROB through a
// one-entry result register with a valid/ready handshake. Each result is
// also forwarded to the reservation station as a one-cycle strobe.
module int_ex #(
    parameter int XLEN     = 64,
    parameter int TAG_W    = 6,
    parameter int MUL_STEP = 4
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic [6:0]       opcode_rs2ex,
    input  logic [2:0]       funct3_rs2ex,
    input  logic [11:0]      imm_rs2ex,
    input  logic [TAG_W-1:0] tag_rs2ex,
    input  logic [XLEN-1:0]  rs1_rs2ex,
    input  logic [XLEN-1:0]  rs2_rs2ex,
    input  logic [TAG_W-1:0] rd_rs2ex,
    input  logic             valid_rs2ex,
    output logic             stop_ex2rs,
    output logic [XLEN-1:0]  result_int2rs,
    output logic [TAG_W-1:0] rd_int2rs,
    output logic             valid_int2rs,
    output logic [XLEN-1:0]  result_ex2rob,
    output logic [TAG_W-1:0] tag_ex2rob,
    output logic             valid_ex2rob,
    input  logic             ready_rob2ex
);

    localparam int SHW   = $clog2(XLEN);
    localparam int STEPS = XLEN / MUL_STEP;
    localparam int CNT_W = $clog2(STEPS) + 1;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MUL   = 2'd1,
        MWAIT = 2'd2
    } state_t;

    state_t            state_r;
    logic [XLEN-1:0]   mcand_r;
    logic [XLEN-1:0]   mplier_r;
    logic [XLEN-1:0]   acc_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [TAG_W-1:0]  mtag_r;
    logic [TAG_W-1:0]  mrd_r;

    logic              accept_s;
    logic              free_s;
    logic              last_step_s;
    logic [6:0]        funct7_s;
    logic [XLEN-1:0]   imm_sx_s;
    logic [SHW-1:0]    sh_r_s;
    logic [SHW-1:0]    sh_i_s;
    logic [XLEN-1:0]   alu_res_s;
    logic              is_mul_s;
    logic [XLEN-1:0]   step_prod_s;
    logic [XLEN-1:0]   final_prod_s;
    logic              load_s;
    logic [XLEN-1:0]   load_val_s;
    logic [TAG_W-1:0]  load_tag_s;
    logic [TAG_W-1:0]  load_rd_s;

    // The result register can take a new value when it is empty or is being drained this edge.
    assign free_s      = ~valid_ex2rob | ready_rob2ex;
    assign stop_ex2rs  = (state_r != IDLE) | (valid_ex2rob & ~ready_rob2ex);
    assign accept_s    = valid_rs2ex & ~stop_ex2rs;
    assign last_step_s = (state_r == MUL) && (cnt_r == CNT_W'(0));

    // Decode the incoming instruction and compute the single-cycle ALU result.
    always_comb begin
        funct7_s  = imm_rs2ex[11:5];
        imm_sx_s  = {{(XLEN-12){imm_rs2ex[11]}}, imm_rs2ex};
        sh_r_s    = rs2_rs2ex[SHW-1:0];
        sh_i_s    = imm_rs2ex[SHW-1:0];
        alu_res_s = {XLEN{1'b0}};
        is_mul_s  = 1'b0;
        case (opcode_rs2ex)
            OP_R: begin
                case (funct7_s)
                    7'b0000000: begin
                        case (funct3_rs2ex)
                            3'b000:  alu_res_s = rs1_rs2ex + rs2_rs2ex;
                            3'b001:  alu_res_s = rs1_rs2ex << sh_r_s;
                            3'b010:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(rs1_rs2ex) < $signed(rs2_rs2ex))};
                            3'b011:  alu_res_s = {{(XLEN-1){1'b0}}, (rs1_rs2ex < rs2_rs2ex)};
                            3'b100:  alu_res_s = rs1_rs2ex ^ rs2_rs2ex;
                            3'b101:  alu_res_s = rs1_rs2ex >> sh_r_s;
                            3'b110:  alu_res_s = rs1_rs2ex | rs2_rs2ex;
                            3'b111:  alu_res_s = rs1_rs2ex & rs2_rs2ex;
                            default: alu_res_s = {XLEN{1'b0}};
                        endcase
                    end
                    7'b0100000: begin
                        case (funct3_rs2ex)
                            3'b000:  alu_res_s = rs1_rs2ex - rs2_rs2ex;
                            3'b101:  alu_res_s = $signed(rs1_rs2ex) >>> sh_r_s;
                            default: alu_res_s = {XLEN{1'b0}};
                        endcase
                    end
                    7'b0000001: begin
                        if (funct3_rs2ex == 3'b000) begin
                            is_mul_s = 1'b1;
                        end else begin
                            is_mul_s = 1'b0;
                        end
                    end
                    default: alu_res_s = {XLEN{1'b0}};
                endcase
            end
            OP_I: begin
                case (funct3_rs2ex)
                    3'b000:  alu_res_s = rs1_rs2ex + imm_sx_s;
                    3'b010:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(rs1_rs2ex) < $signed(imm_sx_s))};
                    3'b011:  alu_res_s = {{(XLEN-1){1'b0}}, (rs1_rs2ex < imm_sx_s)};
                    3'b100:  alu_res_s = rs1_rs2ex ^ imm_sx_s;
                    3'b110:  alu_res_s = rs1_rs2ex | imm_sx_s;
                    3'b111:  alu_res_s = rs1_rs2ex & imm_sx_s;
                    3'b001:  alu_res_s = rs1_rs2ex << sh_i_s;
                    3'b101: begin
                        if (imm_rs2ex[10]) begin
                            alu_res_s = $signed(rs1_rs2ex) >>> sh_i_s;
                        end else begin
                            alu_res_s = rs1_rs2ex >> sh_i_s;
                        end
                    end
                    default: alu_res_s = {XLEN{1'b0}};
                endcase
            end
            default: alu_res_s = {XLEN{1'b0}};
        endcase
    end

    // Partial product of one multiplier digit as a shift-and-add of the multiplicand.
    always_comb begin
        step_prod_s = {XLEN{1'b0}};
        for (int i = 0; i < MUL_STEP; i++) begin
            if (mplier_r[i]) begin
                step_prod_s = step_prod_s + (mcand_r << i);
            end else begin
                step_prod_s = step_prod_s;
            end
        end
        final_prod_s = acc_r + step_prod_s;
    end

    // Choose what, if anything, enters the result register this edge.
    always_comb begin
        load_s     = 1'b0;
        load_val_s = {XLEN{1'b0}};
        load_tag_s = {TAG_W{1'b0}};
        load_rd_s  = {TAG_W{1'b0}};
        if (accept_s && !is_mul_s) begin
            load_s     = 1'b1;
            load_val_s = alu_res_s;
            load_tag_s = tag_rs2ex;
            load_rd_s  = rd_rs2ex;
        end else if (last_step_s && free_s) begin
            load_s     = 1'b1;
            load_val_s = final_prod_s;
            load_tag_s = mtag_r;
            load_rd_s  = mrd_r;
        end else if ((state_r == MWAIT) && free_s) begin
            load_s     = 1'b1;
            load_val_s = acc_r;
            load_tag_s = mtag_r;
            load_rd_s  = mrd_r;
        end else begin
            load_s     = 1'b0;
        end
    end

    // MUL sequencer: latch operands, iterate digit by digit, and hold the product if the register is busy.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_r  <= IDLE;
            mcand_r  <= {XLEN{1'b0}};
            mplier_r <= {XLEN{1'b0}};
            acc_r    <= {XLEN{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            mtag_r   <= {TAG_W{1'b0}};
            mrd_r    <= {TAG_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && is_mul_s) begin
                        state_r  <= MUL;
                        mcand_r  <= rs1_rs2ex;
                        mplier_r <= rs2_rs2ex;
                        acc_r    <= {XLEN{1'b0}};
                        cnt_r    <= CNT_W'(STEPS - 1);
                        mtag_r   <= tag_rs2ex;
                        mrd_r    <= rd_rs2ex;
                    end
                end
                MUL: begin
                    acc_r    <= final_prod_s;
                    mcand_r  <= mcand_r << MUL_STEP;
                    mplier_r <= mplier_r >> MUL_STEP;
                    if (cnt_r == CNT_W'(0)) begin
                        state_r <= free_s ? IDLE : MWAIT;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                MWAIT: begin
                    // The finished product waits in acc_r until the result register frees up.
                    if (free_s) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Result register toward the ROB plus the one-cycle forwarding strobe toward the RS.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            valid_ex2rob  <= 1'b0;
            result_ex2rob <= {XLEN{1'b0}};
            tag_ex2rob    <= {TAG_W{1'b0}};
            valid_int2rs  <= 1'b0;
            result_int2rs <= {XLEN{1'b0}};
            rd_int2rs     <= {TAG_W{1'b0}};
        end else if (load_s) begin
            valid_ex2rob  <= 1'b1;
            result_ex2rob <= load_val_s;
            tag_ex2rob    <= load_tag_s;
            valid_int2rs  <= 1'b1;
            result_int2rs <= load_val_s;
            rd_int2rs     <= load_rd_s;
        end else begin
            valid_int2rs <= 1'b0;
            if (valid_ex2rob && ready_rob2ex) begin
                valid_ex2rob <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_int_ex.sv
// Scoreboard bench for int_ex: a driver issues directed and random
// instructions and queues the reference result. A monitor compares the
// forward strobe and each ROB transfer against those queues.
module tb_int_ex;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic [6:0]  opcode_rs2ex = 7'd0;
    logic [2:0]  funct3_rs2ex = 3'd0;
    logic [11:0] imm_rs2ex = 12'd0;
    logic [5:0]  tag_rs2ex = 6'd0;
    logic [63:0] rs1_rs2ex = 64'd0;
    logic [63:0] rs2_rs2ex = 64'd0;
    logic [5:0]  rd_rs2ex = 6'd0;
    logic        valid_rs2ex = 1'b0;
    logic        stop_ex2rs;
    logic [63:0] result_int2rs;
    logic [5:0]  rd_int2rs;
    logic        valid_int2rs;
    logic [63:0] result_ex2rob;
    logic [5:0]  tag_ex2rob;
    logic        valid_ex2rob;
    logic        ready_rob2ex = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [63:0] res;
        logic [5:0]  tag;
        logic [5:0]  rd;
    } exp_t;

    exp_t rob_q[$];
    exp_t fwd_q[$];

    int_ex #(.XLEN(64), .TAG_W(6), .MUL_STEP(4)) dut (
        .clk(clk), .res_n(res_n),
        .opcode_rs2ex(opcode_rs2ex), .funct3_rs2ex(funct3_rs2ex), .imm_rs2ex(imm_rs2ex),
        .tag_rs2ex(tag_rs2ex), .rs1_rs2ex(rs1_rs2ex), .rs2_rs2ex(rs2_rs2ex),
        .rd_rs2ex(rd_rs2ex), .valid_rs2ex(valid_rs2ex), .stop_ex2rs(stop_ex2rs),
        .result_int2rs(result_int2rs), .rd_int2rs(rd_int2rs), .valid_int2rs(valid_int2rs),
        .result_ex2rob(result_ex2rob), .tag_ex2rob(tag_ex2rob), .valid_ex2rob(valid_ex2rob),
        .ready_rob2ex(ready_rob2ex)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // Reference results from the instruction's meaning (kind), not from its bit encoding.
    // Kinds: 0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND 10 MUL
    // 11 ADDI 12 SLTI 13 SLTIU 14 XORI 15 ORI 16 ANDI 17 SLLI 18 SRLI 19 SRAI 20/21 illegal
    function automatic logic [63:0] model(int k, logic [63:0] a, logic [63:0] b, logic [11:0] imm);
        logic [63:0] s;
        s = {{52{imm[11]}}, imm};
        case (k)
            0:  return a + b;
            1:  return a - b;
            2:  return a << b[5:0];
            3:  return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4:  return (a < b) ? 64'd1 : 64'd0;
            5:  return a ^ b;
            6:  return a >> b[5:0];
            7:  return $signed(a) >>> b[5:0];
            8:  return a | b;
            9:  return a & b;
            10: return a * b;
            11: return a + s;
            12: return ($signed(a) < $signed(s)) ? 64'd1 : 64'd0;
            13: return (a < s) ? 64'd1 : 64'd0;
            14: return a ^ s;
            15: return a | s;
            16: return a & s;
            17: return a << imm[5:0];
            18: return a >> imm[5:0];
            19: return $signed(a) >>> imm[5:0];
            default: return 64'd0;
        endcase
    endfunction

    task automatic gen(int k, output logic [6:0] op, output logic [2:0] f3, output logic [11:0] imm);
        logic [11:0] r;
        logic [6:0]  f7;
        r  = 12'($urandom);
        f7 = 7'b0000000;
        f3 = 3'd0;
        op = (k <= 10) ? OP_R : OP_I;
        case (k)
            0: f3 = 3'd0;  1: begin f3 = 3'd0; f7 = 7'b0100000; end
            2: f3 = 3'd1;  3: f3 = 3'd2;  4: f3 = 3'd3;  5: f3 = 3'd4;
            6: f3 = 3'd5;  7: begin f3 = 3'd5; f7 = 7'b0100000; end
            8: f3 = 3'd6;  9: f3 = 3'd7;  10: begin f3 = 3'd0; f7 = 7'b0000001; end
            11: f3 = 3'd0; 12: f3 = 3'd2; 13: f3 = 3'd3; 14: f3 = 3'd4;
            15: f3 = 3'd6; 16: f3 = 3'd7;
            17: begin f3 = 3'd1; r = {6'd0, r[5:0]}; end
            18: begin f3 = 3'd5; r = {6'd0, r[5:0]}; end
            19: begin f3 = 3'd5; r = {1'b0, 1'b1, 4'd0, r[5:0]}; end
            20: begin
                op = 7'($urandom);
                while (op == OP_R || op == OP_I) op = 7'($urandom);
                f3 = 3'($urandom);
            end
            default: begin
                op = OP_R;
                case ($urandom_range(0, 2))
                    0: begin f7 = 7'b0000001; f3 = 3'($urandom_range(1, 7)); end
                    1: begin
                        f7 = 7'b0100000;
                        f3 = 3'($urandom_range(1, 6));
                        if (f3 == 3'd5) f3 = 3'd7;
                    end
                    default: begin f7 = 7'b0010000; f3 = 3'($urandom); end
                endcase
            end
        endcase
        imm = (op == OP_R) ? {f7, r[4:0]} : r;
    endtask

    function automatic logic [63:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 64'($urandom_range(0, 1000));
            1: return -64'($urandom_range(0, 1000));
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Drive one instruction; if the unit accepts it, queue its reference result.
    task automatic issue_raw(logic [6:0] op, logic [2:0] f3, logic [11:0] imm, logic [63:0] a,
                             logic [63:0] b, logic [5:0] tag, logic [5:0] rd, logic rdy,
                             logic [63:0] expv);
        exp_t e;
        @(negedge clk);
        opcode_rs2ex = op; funct3_rs2ex = f3; imm_rs2ex = imm;
        rs1_rs2ex = a; rs2_rs2ex = b; tag_rs2ex = tag; rd_rs2ex = rd;
        valid_rs2ex = 1'b1; ready_rob2ex = rdy;
        #1;
        if (!stop_ex2rs) begin
            e.res = expv; e.tag = tag; e.rd = rd;
            rob_q.push_back(e);
            fwd_q.push_back(e);
        end
    endtask

    task automatic issue(int k, logic [63:0] a, logic [63:0] b, logic [5:0] tag, logic [5:0] rd, logic rdy);
        logic [6:0] op; logic [2:0] f3; logic [11:0] imm;
        gen(k, op, f3, imm);
        issue_raw(op, f3, imm, a, b, tag, rd, rdy, model(k, a, b, imm));
    endtask

    task automatic idle(logic rdy);
        @(negedge clk);
        valid_rs2ex = 1'b0;
        ready_rob2ex = rdy;
    endtask

    // Monitor: compare every forward strobe and every ROB transfer against the queued references.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (res_n) begin
                if (valid_int2rs) begin
                    if (fwd_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL fwd_unexpected: got strobe rd %0d result %h, required no strobe", rd_int2rs, result_int2rs);
                    end else begin
                        e = fwd_q.pop_front();
                        chk("fwd_result", result_int2rs, e.res);
                        chk("fwd_rd", 64'(rd_int2rs), 64'(e.rd));
                    end
                end
                if (valid_ex2rob && ready_rob2ex) begin
                    if (rob_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL rob_unexpected: got tag %0d result %h, required no transfer", tag_ex2rob, result_ex2rob);
                    end else begin
                        e = rob_q.pop_front();
                        chk("rob_result", result_ex2rob, e.res);
                        chk("rob_tag", 64'(tag_ex2rob), 64'(e.tag));
                    end
                end
            end
        end
    end

    task automatic chk_all_zero(string pfx);
        chk({pfx, "_valid_int2rs"}, 64'(valid_int2rs), 64'd0);
        chk({pfx, "_valid_ex2rob"}, 64'(valid_ex2rob), 64'd0);
        chk({pfx, "_stop_ex2rs"}, 64'(stop_ex2rs), 64'd0);
        chk({pfx, "_result_int2rs"}, result_int2rs, 64'd0);
        chk({pfx, "_result_ex2rob"}, result_ex2rob, 64'd0);
        chk({pfx, "_rd_int2rs"}, 64'(rd_int2rs), 64'd0);
        chk({pfx, "_tag_ex2rob"}, 64'(tag_ex2rob), 64'd0);
    endtask

    initial begin
        int cnt;
        logic [63:0] p;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        res_n = 1'b1;
        ready_rob2ex = 1'b1;

        // ADD 530+714: visible and strobed in the cycle after acceptance, strobe lasts one cycle
        issue_raw(OP_R, 3'd0, 12'h000, 64'd530, 64'd714, 6'd13, 6'd1, 1'b1, 64'd1244);
        idle(1'b1);
        #1;
        chk("add_valid_int2rs", 64'(valid_int2rs), 64'd1);
        chk("add_result", result_int2rs, 64'd1244);
        chk("add_rd", 64'(rd_int2rs), 64'd1);
        chk("add_tag", 64'(tag_ex2rob), 64'd13);
        idle(1'b1);
        #1;
        chk("add_pulse_once", 64'(valid_int2rs), 64'd0);

        // SUB 5-7, SRAI -16 by 2
        issue_raw(OP_R, 3'd0, {7'b0100000, 5'd0}, 64'd5, 64'd7, 6'd2, 6'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        issue_raw(OP_I, 3'd5, 12'h402, -64'd16, 64'd0, 6'd3, 6'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        idle(1'b1);

        // MUL 323*545: stop high for exactly 16 cycles
        issue_raw(OP_R, 3'd0, {7'b0000001, 5'd0}, 64'd323, 64'd545, 6'd7, 6'd9, 1'b1, 64'd176035);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            idle(1'b1);
            #1;
            if (stop_ex2rs) cnt++;
            else break;
        end
        chk("mul_stop_cycles", 64'(cnt), 64'd16);
        chk("mul_done_strobe", 64'(valid_int2rs), 64'd1);
        idle(1'b1);

        // ADDI 10+(-3) with ROB stalled: held, stable, issue blocked
        issue_raw(OP_I, 3'd0, 12'hFFD, 64'd10, 64'd0, 6'd20, 6'd3, 1'b0, 64'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            opcode_rs2ex = OP_R; funct3_rs2ex = 3'd0; imm_rs2ex = 12'd0;
            rs1_rs2ex = 64'd1; rs2_rs2ex = 64'd2; tag_rs2ex = 6'd21; rd_rs2ex = 6'd6;
            valid_rs2ex = 1'b1; ready_rob2ex = 1'b0;
            #1;
            chk("stall_valid_ex2rob", 64'(valid_ex2rob), 64'd1);
            chk("stall_result", result_ex2rob, 64'd7);
            chk("stall_stop", 64'(stop_ex2rs), 64'd1);
        end
        idle(1'b1);
        idle(1'b1);

        // MUL finishing while the ROB is not ready: product held until ready returns
        p = 64'h1_2345_6789 * 64'hAB_CDEF;
        issue_raw(OP_R, 3'd0, {7'b0000001, 5'd0}, 64'h1_2345_6789, 64'hAB_CDEF, 6'd30, 6'd31, 1'b1, p);
        repeat (25) idle(1'b0);
        #1;
        chk("mulstall_valid", 64'(valid_ex2rob), 64'd1);
        chk("mulstall_result", result_ex2rob, p);
        idle(1'b1);
        idle(1'b1);

        // Reset five cycles into a MUL: outputs clear at once, nothing stale afterwards
        issue(10, 64'd99, 64'd77, 6'd40, 6'd41, 1'b1);
        repeat (5) idle(1'b1);
        @(negedge clk);
        res_n = 1'b0;
        #1;
        chk_all_zero("midmul_reset");
        rob_q.delete();
        fwd_q.delete();
        repeat (2) @(negedge clk);
        res_n = 1'b1;
        repeat (30) idle(1'b1);

        // Randomized traffic with random ROB back-pressure
        for (int i = 0; i < 400; i++) begin
            logic rdy;
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) != 0)
                issue($urandom_range(0, 21), rnd_op(), rnd_op(), 6'($urandom), 6'($urandom), rdy);
            else
                idle(rdy);
        end

        // Drain: every accepted instruction must come out
        for (int i = 0; i < 200; i++) begin
            idle(1'b1);
            if (rob_q.size() == 0 && fwd_q.size() == 0) break;
        end
        repeat (2) idle(1'b1);
        chk("drain_rob_pending", 64'(rob_q.size()), 64'd0);
        chk("drain_fwd_pending", 64'(fwd_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
